hdmi_period_scheduler: RTL and testbench

Per-pixel period sequencer for the HDMI transmit path. It owns the raster counters and decides, for every pixel clock, whether the TMDS channels carry control, video preamble, video guard band, active video, or a data-island period. It also pulls 32-pixel packets from an upstream packet source through a valid/ready handshake. Its outputs drive the channel encoders' mode mux; the encoders and serializer sit downstream.

---
 rtl/hdmi_pkg.sv | 39 +++
 rtl/hdmi_period_scheduler_if.sv | 9 +
 rtl/hdmi_timing_counter.sv | 38 +++
 rtl/hdmi_period_scheduler.sv | 145 ++++++++++++++
 tb/tb_hdmi_period_scheduler.sv | 153 +++++++++++++++
 5 files changed

// File: rtl/hdmi_pkg.sv
// Shared HDMI period codes, preamble control patterns and island segment lengths.
package hdmi_pkg;

  typedef enum logic [2:0] {
    P_CONTROL = 3'd0,
    P_VID_PRE = 3'd1,
    P_VID_GB  = 3'd2,
    P_VIDEO   = 3'd3,
    P_DI_PRE  = 3'd4,
    P_DI_GBL  = 3'd5,
    P_DI_DATA = 3'd6,
    P_DI_GBT  = 3'd7
  } period_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_GBL,
    ST_DATA,
    ST_GBT
  } isl_st_e;

  localparam logic [3:0] CTL_NONE    = 4'b0000;
  localparam logic [3:0] CTL_VID_PRE = 4'b0001;
  localparam logic [3:0] CTL_DI_PRE  = 4'b0101;

  localparam int PRE_LEN = 8;
  localparam int GB_LEN  = 2;
  localparam int PKT_LEN = 32;

  function automatic logic [3:0] ctl_of(period_e p);
    case (p)
      P_VID_PRE: return CTL_VID_PRE;
      P_DI_PRE:  return CTL_DI_PRE;
      default:   return CTL_NONE;
    endcase
  endfunction

endpackage

// File: rtl/hdmi_period_scheduler_if.sv
// Packet handshake between the upstream packet source and the period scheduler.
interface hdmi_period_scheduler_if;
  logic       pkt_valid;
  logic       pkt_ready;
  logic [4:0] pkt_idx;

  modport master (output pkt_valid, input pkt_ready, input pkt_idx);
  modport slave  (input pkt_valid, output pkt_ready, output pkt_idx);
endinterface

// File: rtl/hdmi_timing_counter.sv
// Raster counters with wrap, next-line-active flag and sync decode for the pixel
// about to be registered by the scheduler's output stage.
module hdmi_timing_counter #(
  parameter int H_TOTAL  = 800,
  parameter int HS_START = 656,
  parameter int HS_END   = 752,
  parameter int V_ACTIVE = 480,
  parameter int V_TOTAL  = 525,
  parameter int VS_START = 490,
  parameter int VS_END   = 492
) (
  input  logic       pixclk,
  input  logic       rst_n,
  output logic [9:0] tx,
  output logic [9:0] ty,
  output logic       nxt_act,
  output logic       hs,
  output logic       vs
);

  always_ff @(posedge pixclk or negedge rst_n) begin
    if (!rst_n) begin
      tx <= 10'd0;
      ty <= 10'd0;
    end else if (tx == 10'(H_TOTAL-1)) begin
      tx <= 10'd0;
      ty <= (ty == 10'(V_TOTAL-1)) ? 10'd0 : ty + 10'd1;
    end else begin
      tx <= tx + 10'd1;
    end
  end

  // The line after the last one wraps to line 0, which is always active.
  assign nxt_act = (ty == 10'(V_TOTAL-1)) || (ty < 10'(V_ACTIVE-1));
  assign hs      = (tx >= 10'(HS_START)) && (tx < 10'(HS_END));
  assign vs      = (ty >= 10'(VS_START)) && (ty < 10'(VS_END));

endmodule

// File: rtl/hdmi_period_scheduler.sv
// Per-pixel TMDS period sequencer: raster, video preamble/guard band and the
// data-island FSM that pulls 32-pixel packets from upstream.
module hdmi_period_scheduler
  import hdmi_pkg::*;
#(
  parameter int H_ACTIVE = 640,
  parameter int H_TOTAL  = 800,
  parameter int HS_START = 656,
  parameter int HS_END   = 752,
  parameter int V_ACTIVE = 480,
  parameter int V_TOTAL  = 525,
  parameter int VS_START = 490,
  parameter int VS_END   = 492,
  parameter int DI_GAP   = 4,
  parameter int MAX_PKTS = 2
) (
  input  logic                          pixclk,
  input  logic                          rst_n,
  hdmi_period_scheduler_if.slave        pkt,
  output logic [2:0]                    period,
  output logic [3:0]                    ctl,
  output logic                          hsync,
  output logic                          vsync,
  output logic [9:0]                    cx,
  output logic [9:0]                    cy
);

  localparam logic [9:0] DI_START   = 10'(H_ACTIVE + DI_GAP);
  localparam logic [9:0] VPRE_START = 10'(H_TOTAL - PRE_LEN - GB_LEN);
  localparam logic [9:0] VGB_START  = 10'(H_TOTAL - GB_LEN);

  if (MAX_PKTS < 1 || MAX_PKTS > 3 ||
      H_ACTIVE + DI_GAP + 12 + PKT_LEN*MAX_PKTS + 12 + 10 > H_TOTAL) begin : g_param_chk
    $error("hdmi_period_scheduler: data island does not fit in horizontal blanking");
  end

  logic [9:0] tx, ty;
  logic       nla, hs, vs;

  hdmi_timing_counter #(
    .H_TOTAL (H_TOTAL),  .HS_START(HS_START), .HS_END(HS_END),
    .V_ACTIVE(V_ACTIVE), .V_TOTAL (V_TOTAL),
    .VS_START(VS_START), .VS_END  (VS_END)
  ) u_tc (
    .pixclk (pixclk), .rst_n(rst_n),
    .tx     (tx),     .ty   (ty),
    .nxt_act(nla),    .hs   (hs),   .vs(vs)
  );

  // Registered FSM state describes the pixel on the outputs; the counter already
  // holds the next pixel, so *_nxt is the decode for that next pixel.
  isl_st_e    st, st_nxt;
  logic [2:0] ph, ph_nxt;
  logic [4:0] idx, idx_nxt;
  logic [1:0] npkt, npkt_nxt;
  period_e    per_nxt;
  logic       rdy;

  always_ff @(posedge pixclk or negedge rst_n) begin
    if (!rst_n) begin
      st   <= ST_IDLE;
      ph   <= 3'd0;
      idx  <= 5'd0;
      npkt <= 2'd0;
    end else begin
      st   <= st_nxt;
      ph   <= ph_nxt;
      idx  <= idx_nxt;
      npkt <= npkt_nxt;
    end
  end

  always_comb begin
    st_nxt   = st;
    ph_nxt   = ph;
    idx_nxt  = 5'd0;
    npkt_nxt = npkt;
    case (st)
      ST_IDLE: begin
        ph_nxt   = 3'd0;
        npkt_nxt = 2'd0;
        if (tx == DI_START && pkt.pkt_valid) st_nxt = ST_PRE;
      end
      ST_PRE:
        if (ph == 3'(PRE_LEN-1)) begin
          st_nxt = ST_GBL;
          ph_nxt = 3'd0;
        end else ph_nxt = ph + 3'd1;
      ST_GBL:
        if (ph == 3'(GB_LEN-1)) begin
          st_nxt   = ST_DATA;
          ph_nxt   = 3'd0;
          npkt_nxt = 2'd1;
        end else ph_nxt = ph + 3'd1;
      ST_DATA:
        // pkt_valid seen while pkt_ready is on the outputs chains the next packet
        if (idx == 5'(PKT_LEN-1)) begin
          if (pkt.pkt_valid && npkt < 2'(MAX_PKTS)) npkt_nxt = npkt + 2'd1;
          else st_nxt = ST_GBT;
        end else idx_nxt = idx + 5'd1;
      ST_GBT:
        if (ph == 3'(GB_LEN-1)) begin
          st_nxt = ST_IDLE;
          ph_nxt = 3'd0;
        end else ph_nxt = ph + 3'd1;
      default: st_nxt = ST_IDLE;
    endcase

    per_nxt = P_CONTROL;
    case (st_nxt)
      ST_PRE:  per_nxt = P_DI_PRE;
      ST_GBL:  per_nxt = P_DI_GBL;
      ST_DATA: per_nxt = P_DI_DATA;
      ST_GBT:  per_nxt = P_DI_GBT;
      default:
        if (tx < 10'(H_ACTIVE) && ty < 10'(V_ACTIVE)) per_nxt = P_VIDEO;
        else if (nla && tx >= VPRE_START && tx < VGB_START) per_nxt = P_VID_PRE;
        else if (nla && tx >= VGB_START) per_nxt = P_VID_GB;
    endcase
  end

  always_ff @(posedge pixclk or negedge rst_n) begin
    if (!rst_n) begin
      period <= P_CONTROL;
      ctl    <= CTL_NONE;
      hsync  <= 1'b0;
      vsync  <= 1'b0;
      cx     <= 10'd0;
      cy     <= 10'd0;
      rdy    <= 1'b0;
    end else begin
      period <= per_nxt;
      ctl    <= ctl_of(per_nxt);
      hsync  <= hs;
      vsync  <= vs;
      cx     <= tx;
      cy     <= ty;
      rdy    <= (st_nxt == ST_DATA) && (idx_nxt == 5'(PKT_LEN-1));
    end
  end

  assign pkt.pkt_ready = rdy;
  assign pkt.pkt_idx   = idx;

endmodule

// File: tb/tb_hdmi_period_scheduler.sv
// Directed bench for hdmi_period_scheduler; short vertical raster, default horizontal timing.
module tb_hdmi_period_scheduler;
  localparam int HT  = 800;
  localparam int VA  = 4;
  localparam int VT  = 8;
  localparam int VSS = 5;
  localparam int VSE = 6;

  logic       pixclk = 1'b0;
  logic       rst_n  = 1'b0;
  logic [2:0] period;
  logic [3:0] ctl;
  logic       hsync, vsync;
  logic [9:0] cx, cy;

  hdmi_period_scheduler_if pkt_if();

  hdmi_period_scheduler #(
    .V_ACTIVE(VA), .V_TOTAL(VT), .VS_START(VSS), .VS_END(VSE)
  ) dut (
    .pixclk(pixclk), .rst_n(rst_n), .pkt(pkt_if),
    .period(period), .ctl(ctl), .hsync(hsync), .vsync(vsync),
    .cx(cx), .cy(cy)
  );

  always #5 pixclk = ~pixclk;

  int n_chk = 0;
  int n_bad = 0;
  int ex, ey;
  int mode_q [VT];
  int cnt_video, cnt_vpre, cnt_vgb, cnt_hs, cnt_vs, cnt_rdy;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] obs();
    return {29'd0, period, ctl, hsync, vsync, pkt_if.pkt_ready, pkt_if.pkt_idx, cx, cy};
  endfunction

  // Line modes: 0 idle, 1 valid held, 2 valid only for the start pixel,
  // 3 valid rising one pixel late, 4 valid everywhere except the start pixel.
  function automatic logic valid_for(int m, int nc);
    case (m)
      1:       return 1'b1;
      2:       return nc == 644;
      3:       return nc >= 645;
      4:       return nc != 644;
      default: return 1'b0;
    endcase
  endfunction

  function automatic int n_of(int m);
    case (m)
      1:       return 2;
      2:       return 1;
      default: return 0;
    endcase
  endfunction

  function automatic logic [63:0] exp_pix(int x, int y, int n);
    logic [2:0] p;
    logic [3:0] c;
    logic       hs, vs, rdy;
    logic [4:0] idx;
    int         de;
    de = 654 + 32*n;
    p = 3'd0; rdy = 1'b0; idx = 5'd0;
    if (n > 0 && x >= 644 && x < 652) p = 3'd4;
    else if (n > 0 && x >= 652 && x < 654) p = 3'd5;
    else if (n > 0 && x >= 654 && x < de) begin
      p   = 3'd6;
      idx = 5'((x - 654) % 32);
      rdy = (idx == 5'd31);
    end
    else if (n > 0 && x >= de && x < de + 2) p = 3'd7;
    else if (x < 640 && y < VA) p = 3'd3;
    else if (((y + 1) % VT) < VA && x >= 790 && x < 798) p = 3'd1;
    else if (((y + 1) % VT) < VA && x >= 798) p = 3'd2;
    c  = (p == 3'd1) ? 4'b0001 : (p == 3'd4) ? 4'b0101 : 4'b0000;
    hs = (x >= 656 && x < 752);
    vs = (y >= VSS && y < VSE);
    return {29'd0, p, c, hs, vs, rdy, idx, 10'(x), 10'(y)};
  endfunction

  task automatic run_pix(input int npix);
    int nx, ny;
    for (int i = 0; i < npix; i++) begin
      @(negedge pixclk);
      chk($sformatf("pix(%0d,%0d)", ex, ey), obs(), exp_pix(ex, ey, n_of(mode_q[ey])));
      cnt_video += (period == 3'd3) ? 1 : 0;
      cnt_vpre  += (period == 3'd1) ? 1 : 0;
      cnt_vgb   += (period == 3'd2) ? 1 : 0;
      cnt_hs    += hsync ? 1 : 0;
      cnt_vs    += vsync ? 1 : 0;
      cnt_rdy   += pkt_if.pkt_ready ? 1 : 0;
      nx = (ex == HT-1) ? 0 : ex + 1;
      ny = (ex == HT-1) ? (ey + 1) % VT : ey;
      pkt_if.pkt_valid = valid_for(mode_q[ny], nx);
      ex = nx;
      ey = ny;
    end
  endtask

  initial begin
    pkt_if.pkt_valid = 1'b0;
    for (int i = 0; i < VT; i++) mode_q[i] = 0;
    repeat (3) @(negedge pixclk);
    chk("rst_vals", obs(), 64'd0);

    // idle frame: raster, video, preamble and sync only
    rst_n = 1'b1;
    ex = 0; ey = 0;
    cnt_video = 0; cnt_vpre = 0; cnt_vgb = 0; cnt_hs = 0; cnt_vs = 0; cnt_rdy = 0;
    run_pix(HT*VT);
    chk("video_cnt", 64'(cnt_video), 64'd2560);
    chk("vpre_cnt",  64'(cnt_vpre),  64'd32);
    chk("vgb_cnt",   64'(cnt_vgb),   64'd8);
    chk("hs_cnt",    64'(cnt_hs),    64'd768);
    chk("vs_cnt",    64'(cnt_vs),    64'd800);
    chk("rdy_idle",  64'(cnt_rdy),   64'd0);

    // island frame: per-line valid patterns
    mode_q = '{1, 1, 2, 3, 1, 4, 0, 1};
    cnt_rdy = 0;
    run_pix(HT*VT);
    chk("rdy_cnt", 64'(cnt_rdy), 64'd9);

    // reset mid-packet at cx 700
    for (int i = 0; i < VT; i++) mode_q[i] = 1;
    run_pix(701);
    #1 rst_n = 1'b0;
    #1 chk("async_rst", obs(), 64'd0);
    @(posedge pixclk);
    @(negedge pixclk);
    chk("rst_hold", obs(), 64'd0);
    rst_n = 1'b1;
    ex = 0; ey = 0;
    pkt_if.pkt_valid = 1'b1;
    cnt_rdy = 0;
    run_pix(2*HT);
    chk("rdy_after_rst", 64'(cnt_rdy), 64'd4);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
